mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between two requesters: instruction fetch (IF stage) and data access (EX stage issues, MEM stage consumes return).
- Grants address phases with fixed priority, data over inst, and holds each grant until addr_ok.
- Records the owner of every accepted request in an in-order ID queue and steers each data_ok/rdata back to that owner.
- Sits between the pipeline stages and the SRAM-like/AXI bridge.

Parameters:
MAX_OUTSTANDING, 2, accepted-but-unreturned requests allowed (ID queue depth, power of 2, >=2)

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
{inst,data}_req  input  1  request valid, held stable until its addr_ok
{inst,data}_wr  input  1  1=write, 0=read
{inst,data}_size  input  2  0=byte, 1=half, 2=word
{inst,data}_addr  input  32  byte address
{inst,data}_wstrb  input  4  byte enables, writes only
{inst,data}_wdata  input  32  write data
{inst,data}_addr_ok  output  1  address phase accepted this cycle
{inst,data}_data_ok  output  1  response for this requester this cycle
{inst,data}_rdata  output  32  read data, valid with own data_ok
req  output  1  request to memory port
wr, size, addr, wstrb, wdata  output  1/2/32/4/32  muxed from granted requester
addr_ok  input  1  memory port accepted address phase
data_ok  input  1  memory port response, strictly in request order
rdata  input  32  memory port read data

Behaviour:
- Reset: lock cleared, ID queue empty.
  - Outputs: req=0, both addr_ok=0, both data_ok=0.
  - rdata outputs are passthrough of the port rdata, value don't-care while data_ok=0.
- Grant selection, combinational:
  - If lock set, sel=lock_id.
  - Else sel=DATA if data_req, else INST if inst_req, else none.
- Lock:
  - Set with lock_id=sel at the clock edge where req=1 and addr_ok=0.
  - Cleared on the edge where req=1 and addr_ok=1.
  - While locked, the other requester is never granted, even data over inst.
- Output req = sel_req & ~queue_full. wr/size/addr/wstrb/wdata come from sel; they are 0 when no sel.
- {sel}_addr_ok = req & addr_ok, same cycle, zero-latency passthrough; the other requester's addr_ok=0.
- Handshake edge req & addr_ok pushes sel ID into the queue.
- Response path:
  - On data_ok with queue non-empty, pop the head ID.
  - Assert that ID's data_ok in the same cycle; rdata is copied to both rdata outputs.
- Writes also occupy a queue entry and receive data_ok (write ack).
- Full:
  - When count==MAX_OUTSTANDING, req=0 even if a pop occurs in the same cycle; req resumes the next cycle.
  - Lock state is preserved while full.
- Simultaneous push and pop when not full: count unchanged, pointers both advance.
- data_ok while queue empty:
  - Ignored; no requester data_ok, no state change.
  - This is a protocol error, checked by bench assertion.
- Reset mid-operation: queue is discarded, and stray data_ok after reset is dropped under the empty rule above.
- Pointers wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING)+1.

Decomposition:
- Shared header (mycpu_head.h):
  - Requester IDs: ID_INST=1'b0, ID_DATA=1'b1.
  - Size encodings: SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2.
- Sub-module req_id_fifo: 1-bit-wide synchronous FIFO, depth MAX_OUTSTANDING.
  - Ports: push, pop, din, dout, full, empty.
  - The arbiter top holds the lock FSM and muxing.

Test Plan:
- Inst read only, addr 0x1C00_0000, addr_ok after 2 waits: out addr=0x1C00_0000, size=2, req held 3 cycles, inst_addr_ok pulses once. Data_ok 2 cycles later with rdata 0x1234_5678 gives inst_data_ok=1 with inst_rdata=0x1234_5678, data_data_ok=0.
- Both request same cycle, data addr 0x1C00_0100, inst addr 0x1C00_0004, addr_ok always 1: data accepted first, inst next cycle. Two data_ok pulses route data then inst.
- Inst granted, addr_ok low 3 cycles, data_req rises in cycle 1: addr stays 0x1C00_0004 until addr_ok, and data is granted only on the following cycle.
- Two reads accepted, no data_ok, third request pending: req=0 while full. Data_ok in the same cycle still keeps req=0; req=1 the next cycle.
- Data write wr=1, wstrb=4'b0011, wdata=0xDEAD_BEEF, size=1: fields pass unchanged. Write ack data_ok gives data_data_ok=1.
- One request outstanding, resetn=0 for 1 cycle, then data_ok pulse: req=0 during reset, both data_ok stay 0, and the queue is empty afterwards.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// requester IDs, access size encodings, lock state and the muxed command bundle.
package mem_req_arbiter_pkg;

   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_e;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_req_arbiter_req_id_fifo.sv
// 1-bit-wide synchronous FIFO holding the owner ID of each accepted request,
// in acceptance order, so responses can be steered back to their owner.
module mem_req_arbiter_req_id_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;
   assign dout      = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= din;
   end

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access:
// fixed data-over-inst priority, grant held until addr_ok, in-order response steering.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [31:0] addr,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata,
   output lock_state_e dbg_lock_state
);
   lock_state_e r_lock_state;
   logic        r_lock_id;

   logic        w_sel_valid;
   logic        w_sel_id;
   logic        w_sel_req;
   logic        w_full;
   logic        w_empty;
   logic        w_head_id;
   logic        w_push;
   logic        w_pop;
   mem_cmd_t    w_inst_cmd;
   mem_cmd_t    w_data_cmd;
   mem_cmd_t    w_out_cmd;

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_id    = ID_INST;
      if (r_lock_state == LOCK_HELD) begin
         w_sel_valid = 1'b1;
         w_sel_id    = r_lock_id;
      end else if (data_req) begin
         w_sel_valid = 1'b1;
         w_sel_id    = ID_DATA;
      end else if (inst_req) begin
         w_sel_valid = 1'b1;
         w_sel_id    = ID_INST;
      end
   end

   assign w_sel_req = w_sel_valid & ((w_sel_id == ID_DATA) ? data_req : inst_req);

   // A full ID queue blocks the address phase even if a pop lands this cycle.
   assign req    = resetn & w_sel_req & ~w_full;
   assign w_push = req & addr_ok;
   assign w_pop  = resetn & data_ok & ~w_empty;

   assign inst_addr_ok = w_push & (w_sel_id == ID_INST);
   assign data_addr_ok = w_push & (w_sel_id == ID_DATA);
   assign inst_data_ok = w_pop & (w_head_id == ID_INST);
   assign data_data_ok = w_pop & (w_head_id == ID_DATA);
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   assign w_inst_cmd = '{inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
   assign w_data_cmd = '{data_wr, data_size, data_addr, data_wstrb, data_wdata};
   assign w_out_cmd  = w_sel_req ? ((w_sel_id == ID_DATA) ? w_data_cmd : w_inst_cmd) : '0;

   assign wr    = w_out_cmd.wr;
   assign size  = w_out_cmd.size;
   assign addr  = w_out_cmd.addr;
   assign wstrb = w_out_cmd.wstrb;
   assign wdata = w_out_cmd.wdata;

   assign dbg_lock_state = r_lock_state;

   // Lock pins the grant to the requester whose address phase is stalled.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_lock_state <= LOCK_IDLE;
         r_lock_id    <= ID_INST;
      end else if (req && !addr_ok) begin
         r_lock_state <= LOCK_HELD;
         r_lock_id    <= w_sel_id;
      end else if (req && addr_ok) begin
         r_lock_state <= LOCK_IDLE;
      end
   end

   mem_req_arbiter_req_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (w_push),
      .pop    (w_pop),
      .din    (w_sel_id),
      .dout   (w_head_id),
      .full   (w_full),
      .empty  (w_empty)
   );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a queue-based model.
module tb_mem_req_arbiter;
   import mem_req_arbiter_pkg::*;

   localparam int MAXO = 2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   always #5 clk = ~clk;

   logic        inst_req = 0, inst_wr = 0;
   logic [1:0]  inst_size = 0;
   logic [31:0] inst_addr = 0, inst_wdata = 0;
   logic [3:0]  inst_wstrb = 0;
   logic        data_req = 0, data_wr = 0;
   logic [1:0]  data_size = 0;
   logic [31:0] data_addr = 0, data_wdata = 0;
   logic [3:0]  data_wstrb = 0;
   logic        addr_ok = 0, data_ok = 0;
   logic [31:0] rdata = 0;

   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        req, wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   lock_state_e dbg_lock_state;

   mem_req_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
      .dbg_lock_state(dbg_lock_state)
   );

   // ---------------- scoreboard / model ----------------
   int n_tests = 0;
   int n_fail  = 0;
   bit stray_ok = 0;

   // Owners of accepted, unanswered requests, oldest first.
   bit m_q[$];
   // Requester whose address phase is stalled and must keep the port; -1 if none.
   int m_hold = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_sel();
      if (m_hold >= 0) return m_hold;
      if (data_req) return 1;
      if (inst_req) return 0;
      return -1;
   endfunction

   function automatic bit model_req();
      return resetn && (model_sel() >= 0) && (m_q.size() < MAXO);
   endfunction

   always @(posedge clk) begin
      int  sel;
      bit  ereq;
      if (!resetn) begin
         m_q.delete();
         m_hold = -1;
      end else begin
         sel  = model_sel();
         ereq = model_req();
         if (data_ok && m_q.size() > 0) void'(m_q.pop_front());
         if (ereq && addr_ok) begin
            m_q.push_back(sel == 1);
            m_hold = -1;
         end else if (ereq) begin
            m_hold = sel;
         end
      end
   end

   always @(negedge clk) begin
      int  sel;
      bit  ereq, epop, eid;
      sel  = model_sel();
      ereq = model_req();
      epop = resetn && data_ok && (m_q.size() > 0);
      eid  = (m_q.size() > 0) ? m_q[0] : 1'b0;
      assert (stray_ok || !(resetn && data_ok && m_q.size() == 0))
         else $error("data_ok driven with nothing outstanding");
      check("cyc_req", req, ereq);
      check("cyc_inst_addr_ok", inst_addr_ok, ereq && addr_ok && sel == 0);
      check("cyc_data_addr_ok", data_addr_ok, ereq && addr_ok && sel == 1);
      check("cyc_inst_data_ok", inst_data_ok, epop && !eid);
      check("cyc_data_data_ok", data_data_ok, epop && eid);
      if (epop) check(eid ? "cyc_data_rdata" : "cyc_inst_rdata", eid ? data_rdata : inst_rdata, rdata);
      if (ereq) begin
         check("cyc_wr",    wr,    sel == 1 ? data_wr    : inst_wr);
         check("cyc_size",  size,  sel == 1 ? data_size  : inst_size);
         check("cyc_addr",  addr,  sel == 1 ? data_addr  : inst_addr);
         check("cyc_wstrb", wstrb, sel == 1 ? data_wstrb : inst_wstrb);
         check("cyc_wdata", wdata, sel == 1 ? data_wdata : inst_wdata);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inst_req = 0; data_req = 0; addr_ok = 0; data_ok = 0;
      inst_wr = 0; data_wr = 0;
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL timeout: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      int n_req, n_aok;
      bit inst_hs, data_hs;

      repeat (2) tick();
      @(negedge clk);
      check("rst_req", req, 0);
      check("rst_inst_addr_ok", inst_addr_ok, 0);
      check("rst_data_addr_ok", data_addr_ok, 0);
      check("rst_inst_data_ok", inst_data_ok, 0);
      check("rst_data_data_ok", data_data_ok, 0);
      tick();
      resetn = 1;
      tick();

      // Inst read, two wait cycles before addr_ok.
      inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = SIZE_W;
      n_req = 0; n_aok = 0;
      for (int c = 0; c < 5; c++) begin
         addr_ok = (c == 2);
         @(negedge clk);
         if (c == 0) begin
            check("A_addr", addr, 32'h1C00_0000);
            check("A_size", size, 32'd2);
         end
         n_req += int'(req);
         n_aok += int'(inst_addr_ok);
         tick();
         if (c == 2) inst_req = 0;
      end
      addr_ok = 0;
      check("A_req_cycles", n_req, 3);
      check("A_addr_ok_pulses", n_aok, 1);
      data_ok = 1; rdata = 32'h1234_5678;
      @(negedge clk);
      check("A_inst_data_ok", inst_data_ok, 1);
      check("A_inst_rdata", inst_rdata, 32'h1234_5678);
      check("A_data_data_ok", data_data_ok, 0);
      tick();
      idle_inputs();
      tick();

      // Both request together: data first, inst next cycle; responses in order.
      data_req = 1; data_addr = 32'h1C00_0100; data_size = SIZE_W;
      inst_req = 1; inst_addr = 32'h1C00_0004; addr_ok = 1;
      @(negedge clk);
      check("B_data_addr_ok", data_addr_ok, 1);
      check("B_inst_addr_ok0", inst_addr_ok, 0);
      check("B_addr0", addr, 32'h1C00_0100);
      tick();
      data_req = 0;
      @(negedge clk);
      check("B_inst_addr_ok1", inst_addr_ok, 1);
      check("B_addr1", addr, 32'h1C00_0004);
      tick();
      idle_inputs();
      data_ok = 1; rdata = 32'hA5A5_0001;
      @(negedge clk);
      check("B_resp0_data", data_data_ok, 1);
      check("B_resp0_inst", inst_data_ok, 0);
      tick();
      rdata = 32'hA5A5_0002;
      @(negedge clk);
      check("B_resp1_inst", inst_data_ok, 1);
      check("B_resp1_data", data_data_ok, 0);
      tick();
      idle_inputs();

      // Inst grant held while addr_ok is low; data waits despite priority.
      inst_req = 1; inst_addr = 32'h1C00_0004;
      data_addr = 32'h1C00_0200;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) data_req = 1;
         addr_ok = (c >= 3);
         @(negedge clk);
         if (c < 4) check("C_addr_inst", addr, 32'h1C00_0004);
         else       check("C_addr_data", addr, 32'h1C00_0200);
         check("C_data_addr_ok", data_addr_ok, c == 4);
         tick();
         if (c == 3) inst_req = 0;
      end
      idle_inputs();
      data_ok = 1;
      @(negedge clk);
      check("C_resp0_inst", inst_data_ok, 1);
      tick();
      @(negedge clk);
      check("C_resp1_data", data_data_ok, 1);
      tick();
      idle_inputs();

      // Queue full: req drops, stays low on a same-cycle pop, resumes next cycle.
      inst_req = 1; inst_addr = 32'h1C00_0010; addr_ok = 1;
      repeat (2) tick();
      @(negedge clk);
      check("D_req_full", req, 0);
      tick();
      data_ok = 1;
      @(negedge clk);
      check("D_req_full_pop", req, 0);
      check("D_pop_inst", inst_data_ok, 1);
      tick();
      data_ok = 0;
      @(negedge clk);
      check("D_req_resume", req, 1);
      check("D_addr_ok_resume", inst_addr_ok, 1);
      tick();
      idle_inputs();
      data_ok = 1;
      repeat (2) tick();
      idle_inputs();

      // Data write passes fields unchanged and receives a write ack.
      data_req = 1; data_wr = 1; data_size = SIZE_H; data_wstrb = 4'b0011;
      data_wdata = 32'hDEAD_BEEF; data_addr = 32'h1C00_0300; addr_ok = 1;
      @(negedge clk);
      check("E_wr", wr, 1);
      check("E_size", size, 32'd1);
      check("E_wstrb", wstrb, 32'h3);
      check("E_wdata", wdata, 32'hDEAD_BEEF);
      tick();
      idle_inputs();
      data_ok = 1;
      @(negedge clk);
      check("E_write_ack", data_data_ok, 1);
      tick();
      idle_inputs();

      // Reset with one request outstanding; stray data_ok afterwards is dropped.
      inst_req = 1; inst_addr = 32'h1C00_0020; addr_ok = 1;
      tick();
      inst_req = 0; data_req = 1; data_addr = 32'h1C00_0400; resetn = 0;
      @(negedge clk);
      check("F_req_in_reset", req, 0);
      check("F_addr_ok_in_reset", data_addr_ok, 0);
      tick();
      resetn = 1; idle_inputs();
      data_ok = 1; stray_ok = 1;
      @(negedge clk);
      check("F_stray_inst", inst_data_ok, 0);
      check("F_stray_data", data_data_ok, 0);
      tick();
      data_ok = 0; stray_ok = 0;
      data_req = 1; addr_ok = 1;
      @(negedge clk);
      check("F_new_accept", data_addr_ok, 1);
      tick();
      idle_inputs();
      data_ok = 1;
      @(negedge clk);
      check("F_new_resp_data", data_data_ok, 1);
      check("F_new_resp_inst", inst_data_ok, 0);
      tick();
      idle_inputs();

      // Randomized traffic; requesters hold each request until its addr_ok.
      inst_hs = 0; data_hs = 0;
      for (int c = 0; c < 1500; c++) begin
         if (inst_req && inst_hs) inst_req = 0;
         if (!inst_req && $urandom_range(0, 2) == 0) begin
            inst_req   = 1;
            inst_wr    = 1'($urandom_range(0, 1));
            inst_size  = 2'($urandom_range(0, 2));
            inst_addr  = $urandom;
            inst_wstrb = 4'($urandom_range(0, 15));
            inst_wdata = $urandom;
         end
         if (data_req && data_hs) data_req = 0;
         if (!data_req && $urandom_range(0, 2) == 0) begin
            data_req   = 1;
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wstrb = 4'($urandom_range(0, 15));
            data_wdata = $urandom;
         end
         addr_ok = ($urandom_range(0, 3) != 0);
         data_ok = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
         rdata   = $urandom;
         @(negedge clk);
         inst_hs = inst_addr_ok;
         data_hs = data_addr_ok;
         tick();
      end

      idle_inputs();
      for (int c = 0; c < 8; c++) begin
         data_ok = (m_q.size() > 0);
         tick();
      end
      idle_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
